decode_issue_stage: RTL
=======================

Name: decode_issue_stage

Overview:
- Parametrised decode-to-execute issue register; successor to the fixed D/E pipeline register.
- Resolves rs1/rs2 against NUM_FWD priority-ordered bypass sources and detects load-use style hazards from "pending" producers.
- Passes the decoded packet to E through a valid/ready handshake with a one-entry skid buffer, so the upstream ready is a registered signal.
- Supports flush and counts hazard bubbles.

Parameters:
- XLEN, 32, datapath width.
- CTRL_W, 16, width of the opaque decoded control bundle.
- NUM_FWD, 3, number of bypass sources; index 0 is the youngest and has the highest priority.
- CNT_W, 16, width of the bubble counter.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous, active-high reset.
- i_vld_d  in  1  D packet valid.
- o_rdy_d  out  1  stage can accept; registered.
- i_instr_d  in  32  instruction; rs1=[19:15], rs2=[24:20], rd=[11:7].
- i_pc_d  in  XLEN  PC.
- i_ctrl_d  in  CTRL_W  decoded control.
- i_imm_d  in  XLEN  immediate.
- i_rs1_rf  in  XLEN  regfile read data for rs1.
- i_rs2_rf  in  XLEN  regfile read data for rs2.
- i_fwd_vld  in  NUM_FWD  source i writes a register.
- i_fwd_rd  in  NUM_FWD*5  destination of source i.
- i_fwd_data  in  NUM_FWD*XLEN  result of source i.
- i_fwd_pend  in  NUM_FWD  source i result not yet available (e.g. load in E).
- i_flush_e  in  1  kill all held and incoming packets.
- o_vld_e  out  1  E packet valid.
- i_rdy_e  in  1  E accepts.
- o_instr_e  out  32  instruction to E.
- o_pc_e  out  XLEN  PC to E.
- o_ctrl_e  out  CTRL_W  control to E.
- o_imm_e  out  XLEN  immediate to E.
- o_rs1_data_e  out  XLEN  resolved rs1 operand.
- o_rs2_data_e  out  XLEN  resolved rs2 operand.
- o_rs1_e  out  5  rs1 index.
- o_rs2_e  out  5  rs2 index.
- o_rd_e  out  5  rd index.
- o_hazard_stall  out  1  combinational; D must hold.
- o_bubble_cnt  out  CNT_W  hazard bubble count.

Behaviour:
- Reset (i_rst high at the clock edge): o_vld_e=0; skid empty; o_rdy_d=1; every payload output 0; o_bubble_cnt=0.
- Operand resolve, applied independently to rs1 and rs2:
  - rs==0 gives value 0 and never raises a hazard.
  - Otherwise the lowest i with i_fwd_vld[i] and i_fwd_rd[i]==rs and i_fwd_rd[i]!=0 wins.
  - If i_fwd_pend[i] is set, hazard=1 and the value is don't-care; else the value is i_fwd_data[i].
  - If there is no match, the value is the regfile read data.
  - A pending source at lower priority does not cause a hazard when a higher-priority source matches.
- o_hazard_stall = i_vld_d & (hazard_rs1 | hazard_rs2).
- accept = i_vld_d & o_rdy_d & ~o_hazard_stall.
  - The operand values, PC, control, immediate and indices are captured at accept; no later re-resolution.
- Output transfer = o_vld_e & i_rdy_e.
  - When the output register is empty or transferring: load from skid if skid is valid (skid frees), else load the accepted packet, else o_vld_e goes to 0.
  - Accept while the output is full and not transferring writes the skid.
  - o_rdy_d(next) = ~skid_vld(next).
  - Ordering is strictly FIFO; latency is 1 cycle from accept to o_vld_e when the stage is empty.
- When o_vld_e=0 all payload outputs are 0 (NOP packet).
- Flush (i_flush_e): next cycle o_vld_e=0, skid empty, payload 0, o_rdy_d=1.
  - A D packet presented in the flush cycle counts as accepted if accept=1, and is then discarded.
  - Flush overrides accept and transfer.
  - Reset overrides flush.
- Bubble counter: +1 on each cycle with o_hazard_stall=1 and no flush; saturates at 2^CNT_W-1; counts while i_rdy_e is low.
- The stage never issues a packet whose operand depended on a pending source.

Decomposition:
- decode_pkg holds:
  - REG_AW=5 and the field-position constants for rs1/rs2/rd.
  - A typedef for the issue packet struct (instr, pc, ctrl, imm, rs1/rs2 data, indices) parameterised through XLEN/CTRL_W defaults.
  - The NOP packet constant.
- Sub-module operand_resolve (combinational, parameters XLEN and NUM_FWD) produces value and hazard; it is instantiated twice.
- Skid and output registers live in decode_issue_stage.

Test Plan:
- Forwarding priority: rs1=5, src0 rd=5 data 0xAAAA, src2 rd=5 data 0xBBBB, no pend -> o_rs1_data_e=0xAAAA one cycle after accept.
- Zero register: rs2=0, src0 rd=0 data 0x1234 -> o_rs2_data_e=0, no hazard.
- Load-use stall: rs1=7, src0 rd=7 pend=1 for 2 cycles, then pend=0 with data 0x55:
  - o_hazard_stall high for 2 cycles, o_bubble_cnt 0->2.
  - The packet issues with 0x55.
- Backpressure: i_rdy_e=0, send packets A then B.
  - A is held at the output, B goes to skid, and o_rdy_d=0 the next cycle.
  - Raise i_rdy_e: A then B issue on consecutive cycles, in order, with o_rdy_d=1 after B leaves skid.
- Flush with full skid: output=A, skid=B, C presented with i_flush_e=1 -> next cycle o_vld_e=0, payload 0, o_rdy_d=1, and none of A/B/C ever appear.
- Counter saturation and reset: CNT_W=2, hold a hazard for 5 cycles -> count 3.
  - Assert i_rst mid-backpressure -> next cycle all outputs 0, o_rdy_d=1.

Source files
------------

// File: rtl/decode_issue_stage_pkg.sv
// rtl/decode_issue_stage_pkg.sv - shared constants and issue packet type for the decode/issue stage
package decode_pkg;

    localparam int REG_AW = 5;
    localparam int RS1_LSB = 15;
    localparam int RS2_LSB = 20;
    localparam int RD_LSB = 7;

    localparam int PKT_XLEN = 32;
    localparam int PKT_CTRL_W = 16;

    typedef struct packed {
        logic [31:0]           instr;
        logic [PKT_XLEN-1:0]   pc;
        logic [PKT_CTRL_W-1:0] ctrl;
        logic [PKT_XLEN-1:0]   imm;
        logic [PKT_XLEN-1:0]   rs1_data;
        logic [PKT_XLEN-1:0]   rs2_data;
        logic [REG_AW-1:0]     rs1;
        logic [REG_AW-1:0]     rs2;
        logic [REG_AW-1:0]     rd;
    } issue_pkt_t;

    localparam issue_pkt_t ISSUE_NOP = '0;

endpackage

// File: rtl/decode_issue_stage_if.sv
// rtl/decode_issue_stage_if.sv - D-side and E-side packet handshakes of the issue stage
interface decode_issue_stage_if #(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 16
);
    logic              vld_d;
    logic              rdy_d;
    logic [31:0]       instr_d;
    logic [XLEN-1:0]   pc_d;
    logic [CTRL_W-1:0] ctrl_d;
    logic [XLEN-1:0]   imm_d;

    logic              vld_e;
    logic              rdy_e;
    logic [31:0]       instr_e;
    logic [XLEN-1:0]   pc_e;
    logic [CTRL_W-1:0] ctrl_e;
    logic [XLEN-1:0]   imm_e;
    logic [XLEN-1:0]   rs1_data_e;
    logic [XLEN-1:0]   rs2_data_e;
    logic [4:0]        rs1_e;
    logic [4:0]        rs2_e;
    logic [4:0]        rd_e;

    // The stage itself; it receives from D and drives towards E.
    modport slave (
        input  vld_d, instr_d, pc_d, ctrl_d, imm_d, rdy_e,
        output rdy_d, vld_e, instr_e, pc_e, ctrl_e, imm_e,
        output rs1_data_e, rs2_data_e, rs1_e, rs2_e, rd_e
    );

    modport master (
        output vld_d, instr_d, pc_d, ctrl_d, imm_d, rdy_e,
        input  rdy_d, vld_e, instr_e, pc_e, ctrl_e, imm_e,
        input  rs1_data_e, rs2_data_e, rs1_e, rs2_e, rd_e
    );
endinterface

// File: rtl/decode_issue_stage_operand_resolve.sv
// rtl/decode_issue_stage_operand_resolve.sv - priority bypass select and pending-producer hazard for one source operand
module operand_resolve
    import decode_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int NUM_FWD = 3
) (
    input  logic [REG_AW-1:0]         rs,
    input  logic [XLEN-1:0]           rf_data,
    input  logic [NUM_FWD-1:0]        fwd_vld,
    input  logic [NUM_FWD*REG_AW-1:0] fwd_rd,
    input  logic [NUM_FWD*XLEN-1:0]   fwd_data,
    input  logic [NUM_FWD-1:0]        fwd_pend,
    output logic [XLEN-1:0]           value,
    output logic                      hazard
);

    always_comb begin
        value  = rf_data;
        hazard = 1'b0;
        if (rs == '0) begin
            value = '0;
        end else begin
            // Walk from oldest to youngest so the lowest matching index is written last and wins.
            for (int i = NUM_FWD - 1; i >= 0; i--) begin
                if (fwd_vld[i] && (fwd_rd[i*REG_AW +: REG_AW] == rs)) begin
                    value  = fwd_data[i*XLEN +: XLEN];
                    hazard = fwd_pend[i];
                end
            end
        end
    end

endmodule

// File: rtl/decode_issue_stage.sv
// rtl/decode_issue_stage.sv - decode-to-execute issue register with operand bypass, hazard stall and skid buffer
module decode_issue_stage
    import decode_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int CTRL_W  = 16,
    parameter int NUM_FWD = 3,
    parameter int CNT_W   = 16
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    decode_issue_stage_if.slave       bus,
    input  logic [XLEN-1:0]           i_rs1_rf,
    input  logic [XLEN-1:0]           i_rs2_rf,
    input  logic [NUM_FWD-1:0]        i_fwd_vld,
    input  logic [NUM_FWD*REG_AW-1:0] i_fwd_rd,
    input  logic [NUM_FWD*XLEN-1:0]   i_fwd_data,
    input  logic [NUM_FWD-1:0]        i_fwd_pend,
    input  logic                      i_flush_e,
    output logic                      o_hazard_stall,
    output logic [CNT_W-1:0]          o_bubble_cnt
);

    typedef struct packed {
        logic [31:0]       instr;
        logic [XLEN-1:0]   pc;
        logic [CTRL_W-1:0] ctrl;
        logic [XLEN-1:0]   imm;
        logic [XLEN-1:0]   rs1_data;
        logic [XLEN-1:0]   rs2_data;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [REG_AW-1:0] rd;
    } pkt_t;

    logic [REG_AW-1:0] rs1_idx;
    logic [REG_AW-1:0] rs2_idx;
    logic [XLEN-1:0]   rs1_val;
    logic [XLEN-1:0]   rs2_val;
    logic              rs1_haz;
    logic              rs2_haz;

    pkt_t       out_pkt;
    pkt_t       skid_pkt;
    pkt_t       new_pkt;
    logic       out_vld;
    logic       skid_vld;
    logic       skid_vld_nxt;
    logic       rdy_q;
    logic       accept;
    logic       xfer;
    logic       out_free;
    logic [CNT_W-1:0] bubble_cnt;

    assign rs1_idx = bus.instr_d[RS1_LSB +: REG_AW];
    assign rs2_idx = bus.instr_d[RS2_LSB +: REG_AW];

    operand_resolve #(.XLEN(XLEN), .NUM_FWD(NUM_FWD)) u_rs1 (
        .rs(rs1_idx), .rf_data(i_rs1_rf),
        .fwd_vld(i_fwd_vld), .fwd_rd(i_fwd_rd), .fwd_data(i_fwd_data), .fwd_pend(i_fwd_pend),
        .value(rs1_val), .hazard(rs1_haz)
    );

    operand_resolve #(.XLEN(XLEN), .NUM_FWD(NUM_FWD)) u_rs2 (
        .rs(rs2_idx), .rf_data(i_rs2_rf),
        .fwd_vld(i_fwd_vld), .fwd_rd(i_fwd_rd), .fwd_data(i_fwd_data), .fwd_pend(i_fwd_pend),
        .value(rs2_val), .hazard(rs2_haz)
    );

    assign o_hazard_stall = bus.vld_d & (rs1_haz | rs2_haz);
    assign accept         = bus.vld_d & rdy_q & ~o_hazard_stall;
    assign xfer           = out_vld & bus.rdy_e;
    assign out_free       = ~out_vld | xfer;

    always_comb begin
        new_pkt.instr    = bus.instr_d;
        new_pkt.pc       = bus.pc_d;
        new_pkt.ctrl     = bus.ctrl_d;
        new_pkt.imm      = bus.imm_d;
        new_pkt.rs1_data = rs1_val;
        new_pkt.rs2_data = rs2_val;
        new_pkt.rs1      = rs1_idx;
        new_pkt.rs2      = rs2_idx;
        new_pkt.rd       = bus.instr_d[RD_LSB +: REG_AW];
    end

    // rdy_q is low whenever the skid holds a packet, so the skid never has to absorb while full.
    always_comb begin
        skid_vld_nxt = skid_vld;
        if (i_flush_e || out_free) begin
            skid_vld_nxt = 1'b0;
        end else if (accept) begin
            skid_vld_nxt = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            out_vld  <= 1'b0;
            out_pkt  <= '0;
            skid_vld <= 1'b0;
            skid_pkt <= '0;
            rdy_q    <= 1'b1;
        end else begin
            skid_vld <= skid_vld_nxt;
            rdy_q    <= ~skid_vld_nxt;
            if (i_flush_e) begin
                out_vld  <= 1'b0;
                out_pkt  <= '0;
                skid_pkt <= '0;
            end else if (out_free) begin
                if (skid_vld) begin
                    out_vld  <= 1'b1;
                    out_pkt  <= skid_pkt;
                    skid_pkt <= '0;
                end else if (accept) begin
                    out_vld <= 1'b1;
                    out_pkt <= new_pkt;
                end else begin
                    out_vld <= 1'b0;
                    out_pkt <= '0;
                end
            end else if (accept) begin
                skid_pkt <= new_pkt;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            bubble_cnt <= '0;
        end else if (o_hazard_stall && !i_flush_e && (bubble_cnt != '1)) begin
            bubble_cnt <= bubble_cnt + 1'b1;
        end
    end

    assign o_bubble_cnt   = bubble_cnt;
    assign bus.rdy_d      = rdy_q;
    assign bus.vld_e      = out_vld;
    assign bus.instr_e    = out_pkt.instr;
    assign bus.pc_e       = out_pkt.pc;
    assign bus.ctrl_e     = out_pkt.ctrl;
    assign bus.imm_e      = out_pkt.imm;
    assign bus.rs1_data_e = out_pkt.rs1_data;
    assign bus.rs2_data_e = out_pkt.rs2_data;
    assign bus.rs1_e      = out_pkt.rs1;
    assign bus.rs2_e      = out_pkt.rs2;
    assign bus.rd_e       = out_pkt.rd;

endmodule
